// File: rtl/seq_divider_5bit_if.sv
// Start/done handshake and operand/result bus for seq_divider_5bit.
// master: requester (start, dividend, divisor); slave: divider (busy, done, results).
interface seq_divider_5bit_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider_5bit.sv
// Sequential unsigned restoring divider, one trial subtraction per cycle.
// Ports: clk, rst_n (async active-low), bus (slave: start/operands in, busy/done/results out).
module seq_divider_5bit #(
    parameter int WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_divider_5bit_if.slave   bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    // The partial remainder's top bit is always zero between iterations
    // (R < D after each step), so only the low WIDTH bits are stored.
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Trial subtraction: {R, Q msb} - {0, D} as add of ~{0, D} with carry-in 1.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic             unused_sum_msb;

    assign shifted   = {r_q, q_q[WIDTH-1]};
    assign sum       = {1'b0, shifted} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
    assign no_borrow = sum[WIDTH+1];
    // When there is no borrow the difference fits in WIDTH bits.
    assign unused_sum_msb = sum[WIDTH];

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        d_d        = d_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        dbz_pend_d = dbz_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    q_d        = bus.dividend;
                    d_d        = bus.divisor;
                    r_d        = '0;
                    cnt_d      = '0;
                    dbz_pend_d = (bus.divisor == '0);
                end
            end
            RUN: begin
                q_d   = {q_q[WIDTH-2:0], no_borrow};
                r_d   = no_borrow ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = dbz_pend_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            q_q        <= '0;
            d_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            dbz_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            d_q        <= d_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            dbz_pend_q <= dbz_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_5bit.sv
// Scoreboard bench for seq_divider_5bit: directed cases, full sweep, random ops.
// Expected results come from a plain-arithmetic model pushed at issue time.
module tb_seq_divider_5bit;

    localparam int W = 5;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    seq_divider_5bit_if #(.WIDTH(W)) bus ();

    seq_divider_5bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.z = 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 0;
        end
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", int'(bus.quotient), e.q);
                chk("remainder", int'(bus.remainder), e.r);
                chk("div_by_zero", int'(bus.div_by_zero), e.z);
                if (e.b != 0) begin
                    chk("q_times_d_plus_r",
                        int'(bus.quotient) * e.b + int'(bus.remainder), e.a);
                    chk("rem_lt_div", int'(int'(bus.remainder) < e.b), 1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || bus.done) && n < 20);
        if (n >= 20) chk("idle_timeout", n, 0);
    endtask

    // Issue one operation, check busy length and start-to-done latency.
    task automatic op(input int a, input int b, input bit jitter);
        int n;
        int busy_n;
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        busy_n = int'(bus.busy);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy) busy_n++;
            if (jitter && !bus.done) begin
                bus.start    = 1'($urandom);
                bus.dividend = W'($urandom);
                bus.divisor  = W'($urandom);
            end
        end while (!bus.done && n < 20);
        bus.start = 1'b0;
        chk("latency", n, W);
        chk("busy_cycles", busy_n, W);
        @(posedge clk);
        #1;
        chk("done_pulse_width", int'(bus.done), 0);
    endtask

    initial begin
        int n;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        rst_n = 1'b0;
        #5;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_quotient", int'(bus.quotient), 0);
        chk("rst_remainder", int'(bus.remainder), 0);
        chk("rst_dbz", int'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(23, 4, 1'b0);
        op(31, 1, 1'b0);
        op(3, 9, 1'b0);
        repeat (4) @(negedge clk);
        chk("hold_quotient", int'(bus.quotient), 0);
        chk("hold_remainder", int'(bus.remainder), 3);

        op(7, 0, 1'b0);
        op(20, 5, 1'b0);

        // start held high; operands changed during RUN.
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = W'(30);
        bus.divisor  = W'(7);
        sb.push_back(model(30, 7));
        @(posedge clk);
        #1;
        bus.dividend = W'(9);
        bus.divisor  = W'(3);
        sb.push_back(model(9, 3));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 20);
        chk("held_latency", n, W);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.done && n < 20);
        chk("held_spacing", n, W + 2);
        bus.start = 1'b0;

        // Asynchronous reset in the middle of 29/3.
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = W'(29);
        bus.divisor  = W'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_abort_busy", int'(bus.busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_quotient", int'(bus.quotient), 0);
        chk("abort_remainder", int'(bus.remainder), 0);
        chk("abort_dbz", int'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("abort_no_done", n, 0);
        op(29, 3, 1'b0);

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                op(a, b, 1'b0);
            end
        end

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op(int'($urandom_range(0, (1 << W) - 1)),
               int'($urandom_range(0, (1 << W) - 1)), 1'b1);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider_5bit.md
Name: seq_divider_5bit

Overview:
- Sequential unsigned restoring divider. It is the inverse-direction companion to the team's combinational 5-bit adder/subtractor.
- Computes quotient and remainder of dividend/divisor over WIDTH cycles, one trial subtraction per cycle.
- Each trial subtraction uses the add-inverted-B-with-carry-in-1 scheme; carry-out 1 means no borrow.
- Sits behind a simple start/done handshake for use by datapath control in the lab designs.

Parameters:
WIDTH, 5, operand/quotient/remainder width in bits (valid range 2..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; captured on the accepted start edge
divisor  input  WIDTH  unsigned divisor; captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  result quotient; holds until the next accepted start
remainder  output  WIDTH  result remainder; holds until the next accepted start
div_by_zero  output  1  set with done when captured divisor == 0; holds like quotient

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset release is clean in any state; an in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1 at a clock edge (edge 0).
  - RUN -> DONE after exactly WIDTH iterations.
  - DONE -> IDLE unconditionally on the next edge.
- Edge 0 (accept):
  - Latch dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits) and the counter.
  - Latch div_by_zero_next = (divisor==0).
  - busy=1 from edge 0.
- Edges 1..WIDTH (iterations):
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed as an add of the inverted operand with carry-in 1.
  - If there is no borrow (carry-out=1): R<=T and Q<={Q[WIDTH-2:0],1}.
  - Else: R<={R[WIDTH-1:0],Q[WIDTH-1]} and Q<={Q[WIDTH-2:0],0}.
- Edge WIDTH:
  - State=DONE, busy=0, done=1.
  - quotient<=final Q, remainder<=final R[WIDTH-1:0], div_by_zero<=latched flag.
- Edge WIDTH+1: done=0, state=IDLE.
- Latency: start edge to done-high = WIDTH edges (5 by default). Minimum start-to-start spacing = WIDTH+2 cycles.
- start is ignored in RUN and DONE; no queuing, no effect on the operation in flight. dividend/divisor may change freely after edge 0.
- Divisor 0: no special path. The algorithm yields quotient = all ones and remainder = dividend, with div_by_zero=1. Latency is unchanged.
- Dividend < divisor: quotient=0, remainder=dividend.
- Results and div_by_zero are updated only at the DONE entry edge. In all other cycles they hold their previous values, including through IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with dividend=23, divisor=4 -> busy high for 5 cycles; done pulses 1 cycle at edge 5; quotient=5, remainder=3, div_by_zero=0.
- dividend=31, divisor=1 -> quotient=31, remainder=0. Then dividend=3, divisor=9 -> quotient=0, remainder=3. Results hold while IDLE.
- dividend=7, divisor=0 -> after 5 cycles quotient=31, remainder=7, div_by_zero=1. A following 20/5 clears it: quotient=4, remainder=0, div_by_zero=0.
- start=1 held continuously with 30/7 -> first result quotient=4, remainder=2. Operands are changed to 9/3 during RUN with no effect; the next op is accepted only at the IDLE edge, with done pulses exactly 7 cycles apart.
- Assert rst_n=0 mid-RUN (edge 2 of 29/3) -> all outputs 0 immediately (asynchronous) and no done pulse. After release, 29/3 -> quotient=9, remainder=2.
- Exhaustive sweep of all 32x32 operand pairs (WIDTH=5) vs reference model -> quotient*divisor+remainder==dividend and remainder<divisor for every divisor≠0; divisor=0 as specified above.
